// File: rtl/udma_qspi_pkg.sv
// Shared types and defaults for the uDMA QSPI pad-side chip-select sequencer.
package udma_qspi_pkg;

  localparam int unsigned QSPI_CNT_W = 8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACTIVE,
    ST_HOLD,
    ST_GAP
  } qspi_cs_state_e;

endpackage

// File: rtl/udma_qspi_delay_cnt.sv
// Loadable saturating down-counter; done while the count is at its last window cycle.
module udma_qspi_delay_cnt
  import udma_qspi_pkg::*;
#(
  parameter int unsigned CNT_W = QSPI_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  output logic [CNT_W-1:0] count,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign count = cnt_q;
  assign done  = (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/udma_qspi_cs_sequencer.sv
// Pad-side CS/OE sequencer with setup, hold and idle-gap windows for the uDMA SPI core.
// Optional bus-turnaround OE delay: define QSPI_OE_TURNAROUND_EN.
module udma_qspi_cs_sequencer
  import udma_qspi_pkg::*;
#(
  parameter int unsigned NUM_CS = 4,
  parameter int unsigned NUM_SD = 4,
  parameter int unsigned CNT_W  = QSPI_CNT_W
) (
  input  logic              periph_clk_i,
  input  logic              rstn_i,
  input  logic [CNT_W-1:0]  cfg_setup_i,
  input  logic [CNT_W-1:0]  cfg_hold_i,
  input  logic [CNT_W-1:0]  cfg_idle_i,
  input  logic              cfg_cpol_i,
  input  logic [NUM_CS-1:0] core_csn_i,
  input  logic              core_sck_i,
  input  logic [NUM_SD-1:0] core_oen_i,
  input  logic [NUM_SD-1:0] core_sdo_i,
  output logic              core_stall_o,
  output logic [NUM_CS-1:0] pad_csn_o,
  output logic              pad_sck_o,
  output logic [NUM_SD-1:0] pad_sd_oe_o,
  output logic [NUM_SD-1:0] pad_sdo_o,
  output logic              busy_o,
  output logic              eot_o,
  output logic              err_o
);

  localparam int unsigned SEL_W = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;

  qspi_cs_state_e    state_q, state_d;
  logic [SEL_W-1:0]  cs_sel_q, cs_sel_d, req_idx;
  logic [CNT_W-1:0]  hold_q, idle_q, cnt_load_val, cnt_count;
  logic              cpol_q, cpol_cur;
  logic [NUM_CS-1:0] req_vec;
  logic              req_any, req_multi, leave;
  logic              cnt_load, cnt_en, cnt_done;
  logic [NUM_SD-1:0] oe_req;

  logic [NUM_CS-1:0] pad_csn_q, pad_csn_d;
  logic              pad_sck_q, pad_sck_d;
  logic [NUM_SD-1:0] oe_q, oe_d, sdo_q, sdo_d;
  logic              stall_q, stall_d, busy_q, busy_d, eot_q, eot_d, err_q, err_d;
  logic              active_d;

  assign req_vec   = ~core_csn_i;
  assign req_any   = |req_vec;
  assign req_multi = |(req_vec & (req_vec - NUM_CS'(1)));
  // Leave ACTIVE on release of the selected CS or on any other CS being pulled low.
  assign leave     = (core_csn_i != ~(NUM_CS'(1) << cs_sel_q));
  assign cpol_cur  = (state_q == ST_IDLE) ? cfg_cpol_i : cpol_q;

  always_comb begin
    req_idx = '0;
    for (int unsigned i = NUM_CS; i > 0; i--) begin
      if (req_vec[i-1]) req_idx = SEL_W'(i - 1);
    end
  end

`ifdef QSPI_OE_TURNAROUND_EN
  logic [NUM_SD-1:0] oen_prev_q;

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) oen_prev_q <= '1;
    else         oen_prev_q <= core_oen_i;
  end

  // A line only drives once its enable has been low for two consecutive cycles.
  assign oe_req = ~core_oen_i & ~oen_prev_q;
`else
  assign oe_req = ~core_oen_i;
`endif

  udma_qspi_delay_cnt #(.CNT_W(CNT_W)) u_delay_cnt (
    .clk      (periph_clk_i),
    .rst_n    (rstn_i),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .count    (cnt_count),
    .done     (cnt_done)
  );

  assign cnt_load = (state_d != state_q) && (state_d inside {ST_SETUP, ST_HOLD, ST_GAP});
  assign cnt_en   = (state_q inside {ST_SETUP, ST_HOLD, ST_GAP});

  always_comb begin
    cnt_load_val = cfg_setup_i;
    case (state_d)
      ST_HOLD: cnt_load_val = hold_q;
      ST_GAP:  cnt_load_val = idle_q;
      default: cnt_load_val = cfg_setup_i;
    endcase
  end

  always_ff @(posedge periph_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      cs_sel_q  <= '0;
      hold_q    <= '0;
      idle_q    <= '0;
      cpol_q    <= 1'b0;
      pad_csn_q <= '1;
      pad_sck_q <= 1'b0;
      oe_q      <= '0;
      sdo_q     <= '0;
      stall_q   <= 1'b0;
      busy_q    <= 1'b0;
      eot_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cs_sel_q <= cs_sel_d;
      if (state_q == ST_IDLE) begin
        hold_q <= cfg_hold_i;
        idle_q <= cfg_idle_i;
        cpol_q <= cfg_cpol_i;
      end
      pad_csn_q <= pad_csn_d;
      pad_sck_q <= pad_sck_d;
      oe_q      <= oe_d;
      sdo_q     <= sdo_d;
      stall_q   <= stall_d;
      busy_q    <= busy_d;
      eot_q     <= eot_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cs_sel_d = cs_sel_q;
    unique case (state_q)
      ST_IDLE: begin
        if (req_any) begin
          cs_sel_d = req_idx;
          state_d  = (cfg_setup_i != '0) ? ST_SETUP : ST_ACTIVE;
        end
      end
      ST_SETUP:  if (cnt_done) state_d = ST_ACTIVE;
      ST_ACTIVE: begin
        if (leave) begin
          if (hold_q != '0)      state_d = ST_HOLD;
          else if (idle_q != '0) state_d = ST_GAP;
          else                   state_d = ST_IDLE;
        end
      end
      ST_HOLD:   if (cnt_done) state_d = (idle_q != '0) ? ST_GAP : ST_IDLE;
      ST_GAP:    if (cnt_done) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Outputs are registered from the next state so pads follow the FSM with no extra lag.
  always_comb begin
    active_d  = (state_d == ST_ACTIVE);
    pad_csn_d = '1;
    if (state_d inside {ST_SETUP, ST_ACTIVE, ST_HOLD}) pad_csn_d = ~(NUM_CS'(1) << cs_sel_d);
    pad_sck_d = active_d ? core_sck_i : cpol_cur;
    sdo_d     = active_d ? core_sdo_i : '0;
    oe_d      = active_d ? oe_req : '0;
    busy_d    = (state_d != ST_IDLE);
    stall_d   = busy_d && !active_d;
    // eot lands on the final HOLD cycle; count==2 means the next cycle is that final one.
    eot_d     = ((state_q == ST_ACTIVE) && leave && (hold_q <= CNT_W'(1))) ||
                ((state_q == ST_HOLD) && (cnt_count == CNT_W'(2)));
    err_d     = (state_q == ST_IDLE) && req_multi;
  end

  assign core_stall_o = stall_q | (rstn_i && (state_q == ST_IDLE) && req_any);
  assign pad_csn_o    = pad_csn_q;
  assign pad_sck_o    = pad_sck_q;
  assign pad_sd_oe_o  = oe_q;
  assign pad_sdo_o    = sdo_q;
  assign busy_o       = busy_q;
  assign eot_o        = eot_q;
  assign err_o        = err_q;

endmodule

// File: tb/tb_udma_qspi_cs_sequencer.sv
// Scoreboard bench for udma_qspi_cs_sequencer: per-cycle expectations queued, checked at negedge.
module tb_udma_qspi_cs_sequencer;

  localparam int S_CSN = 0, S_SCK = 1, S_OE = 2, S_SDO = 3;
  localparam int S_STALL = 4, S_BUSY = 5, S_EOT = 6, S_ERR = 7;
`ifdef QSPI_OE_TURNAROUND_EN
  localparam logic [31:0] OE_FIRST = 32'h0;
`else
  localparam logic [31:0] OE_FIRST = 32'h2;
`endif

  logic       clk = 1'b0;
  logic       rstn;
  logic [7:0] cfg_setup, cfg_hold, cfg_idle;
  logic       cfg_cpol;
  logic [3:0] core_csn, core_oen, core_sdo;
  logic       core_sck;
  logic       core_stall_o, pad_sck_o, busy_o, eot_o, err_o;
  logic [3:0] pad_csn_o, pad_sd_oe_o, pad_sdo_o;

  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  int b;

  typedef struct {
    int          cyc;
    int          sig;
    logic [31:0] val;
    string       name;
  } exp_t;
  exp_t sb[$];

  udma_qspi_cs_sequencer #(.NUM_CS(4), .NUM_SD(4), .CNT_W(8)) dut (
    .periph_clk_i (clk),
    .rstn_i       (rstn),
    .cfg_setup_i  (cfg_setup),
    .cfg_hold_i   (cfg_hold),
    .cfg_idle_i   (cfg_idle),
    .cfg_cpol_i   (cfg_cpol),
    .core_csn_i   (core_csn),
    .core_sck_i   (core_sck),
    .core_oen_i   (core_oen),
    .core_sdo_i   (core_sdo),
    .core_stall_o (core_stall_o),
    .pad_csn_o    (pad_csn_o),
    .pad_sck_o    (pad_sck_o),
    .pad_sd_oe_o  (pad_sd_oe_o),
    .pad_sdo_o    (pad_sdo_o),
    .busy_o       (busy_o),
    .eot_o        (eot_o),
    .err_o        (err_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] probe(input int s);
    case (s)
      S_CSN:   probe = 32'(pad_csn_o);
      S_SCK:   probe = 32'(pad_sck_o);
      S_OE:    probe = 32'(pad_sd_oe_o);
      S_SDO:   probe = 32'(pad_sdo_o);
      S_STALL: probe = 32'(core_stall_o);
      S_BUSY:  probe = 32'(busy_o);
      S_EOT:   probe = 32'(eot_o);
      S_ERR:   probe = 32'(err_o);
      default: probe = '1;
    endcase
  endfunction

  task automatic expect_at(input int c, input int s, input logic [31:0] v, input string nm);
    exp_t e;
    int   pos;
    e.cyc = c; e.sig = s; e.val = v; e.name = nm;
    pos = sb.size();
    while (pos > 0 && sb[pos-1].cyc > c) pos--;
    sb.insert(pos, e);
  endtask

  task automatic expect_rng(input int c0, input int c1, input int s, input logic [31:0] v,
                            input string nm);
    for (int c = c0; c <= c1; c++) expect_at(c, s, v, nm);
  endtask

  task automatic go(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t        e;
    logic [31:0] act;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      act = probe(e.sig);
      n_cmp++;
      if (e.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s stale check at cyc %0d (due %0d) got=0x%0h expected=0x%0h",
                 e.name, cyc, e.cyc, act, e.val);
      end else if (act !== e.val) begin
        n_bad++;
        $display("FAIL %s cyc=%0d got=0x%0h expected=0x%0h", e.name, cyc, act, e.val);
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: run did not complete, got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rstn = 1'b0;
    cfg_setup = 8'd0; cfg_hold = 8'd0; cfg_idle = 8'd0; cfg_cpol = 1'b0;
    core_csn = 4'hF; core_oen = 4'hF; core_sdo = 4'h0; core_sck = 1'b0;

    // Reset values
    expect_at(2, S_CSN, 32'hF, "rst_csn");
    expect_at(2, S_SCK, 32'h0, "rst_sck");
    expect_at(2, S_OE, 32'h0, "rst_oe");
    expect_at(2, S_SDO, 32'h0, "rst_sdo");
    expect_at(2, S_STALL, 32'h0, "rst_stall");
    expect_at(2, S_BUSY, 32'h0, "rst_busy");
    expect_at(2, S_EOT, 32'h0, "rst_eot");
    expect_at(2, S_ERR, 32'h0, "rst_err");
    go(3);
    rstn = 1'b1;

    // T1: S=3 H=2 I=4 windows, pass-through and OE turnaround inside ACTIVE
    b = cyc + 2;
    cfg_setup = 8'd3; cfg_hold = 8'd2; cfg_idle = 8'd4;
    expect_at(b+10, S_CSN, 32'hF, "t1_csn_pre");
    expect_rng(b+11, b+32, S_CSN, 32'hE, "t1_csn_low");
    expect_at(b+33, S_CSN, 32'hF, "t1_csn_rel");
    expect_at(b+9, S_STALL, 32'h0, "t1_stall_pre");
    expect_rng(b+10, b+13, S_STALL, 32'h1, "t1_stall_setup");
    expect_at(b+14, S_STALL, 32'h0, "t1_stall_active");
    expect_rng(b+31, b+36, S_STALL, 32'h1, "t1_stall_hold_gap");
    expect_at(b+37, S_STALL, 32'h0, "t1_stall_idle");
    expect_at(b+10, S_BUSY, 32'h0, "t1_busy_detect");
    expect_at(b+11, S_BUSY, 32'h1, "t1_busy_on");
    expect_at(b+36, S_BUSY, 32'h1, "t1_busy_gap");
    expect_at(b+37, S_BUSY, 32'h0, "t1_busy_off");
    expect_at(b+31, S_EOT, 32'h0, "t1_eot_pre");
    expect_at(b+32, S_EOT, 32'h1, "t1_eot");
    expect_at(b+33, S_EOT, 32'h0, "t1_eot_post");
    expect_at(b+11, S_ERR, 32'h0, "t1_err");
    expect_at(b+13, S_SCK, 32'h0, "t1_sck_setup");
    expect_at(b+14, S_SCK, 32'h1, "t1_sck_pass");
    expect_at(b+21, S_SCK, 32'h0, "t1_sck_low");
    expect_at(b+31, S_SCK, 32'h0, "t1_sck_hold");
    expect_at(b+16, S_SDO, 32'hA, "t1_sdo_pass");
    expect_at(b+31, S_SDO, 32'h0, "t1_sdo_hold");
    expect_at(b+18, S_OE, 32'h0, "t1_oe_pre");
    expect_at(b+19, S_OE, OE_FIRST, "t1_oe_first");
    expect_at(b+20, S_OE, 32'h2, "t1_oe_on");
    expect_at(b+31, S_OE, 32'h0, "t1_oe_hold");
    go(b+10); core_csn = 4'hE;
    go(b+12); core_sck = 1'b1;
    go(b+15); core_sdo = 4'hA;
    go(b+18); core_oen = 4'hD;
    go(b+20); core_sck = 1'b0; cfg_hold = 8'd0;
    go(b+30); core_csn = 4'hF; core_sck = 1'b1;
    go(b+31); core_oen = 4'hF; core_sdo = 4'h0; core_sck = 1'b0;
    go(b+38);

    // T2: all windows zero
    b = cyc + 2;
    cfg_setup = 8'd0; cfg_hold = 8'd0; cfg_idle = 8'd0;
    expect_at(b+5, S_CSN, 32'hF, "t2_csn_pre");
    expect_rng(b+6, b+9, S_CSN, 32'hB, "t2_csn_low");
    expect_at(b+10, S_CSN, 32'hF, "t2_csn_rel");
    expect_at(b+5, S_STALL, 32'h1, "t2_stall_detect");
    expect_at(b+6, S_STALL, 32'h0, "t2_stall_active");
    expect_at(b+10, S_STALL, 32'h0, "t2_stall_idle");
    expect_at(b+9, S_EOT, 32'h0, "t2_eot_pre");
    expect_at(b+10, S_EOT, 32'h1, "t2_eot");
    expect_at(b+11, S_EOT, 32'h0, "t2_eot_post");
    expect_at(b+9, S_BUSY, 32'h1, "t2_busy_on");
    expect_at(b+10, S_BUSY, 32'h0, "t2_busy_off");
    expect_at(b+6, S_SCK, 32'h1, "t2_sck_pass");
    expect_at(b+10, S_SCK, 32'h0, "t2_sck_idle");
    go(b+5); core_csn = 4'hB; core_sck = 1'b1;
    go(b+9); core_csn = 4'hF; core_sck = 1'b0;
    go(b+12);

    // T3: multi-CS request, lowest index wins and error pulses once
    b = cyc + 2;
    cfg_setup = 8'd1; cfg_hold = 8'd1; cfg_idle = 8'd1;
    expect_at(b+5, S_ERR, 32'h0, "t3_err_pre");
    expect_at(b+6, S_ERR, 32'h1, "t3_err");
    expect_at(b+7, S_ERR, 32'h0, "t3_err_post");
    expect_rng(b+6, b+8, S_CSN, 32'hD, "t3_csn_sel1");
    expect_at(b+9, S_CSN, 32'hF, "t3_csn_rel");
    expect_at(b+7, S_EOT, 32'h0, "t3_eot_pre");
    expect_at(b+8, S_EOT, 32'h1, "t3_eot");
    expect_at(b+9, S_EOT, 32'h0, "t3_eot_post");
    expect_at(b+10, S_BUSY, 32'h0, "t3_busy_off");
    go(b+5); core_csn = 4'h5;
    go(b+7); core_csn = 4'hF;
    go(b+12);

    // T4: asynchronous reset during HOLD
    b = cyc + 2;
    cfg_setup = 8'd1; cfg_hold = 8'd3; cfg_idle = 8'd2;
    expect_at(b+9, S_CSN, 32'hD, "t4_csn_active");
    expect_at(b+9, S_BUSY, 32'h1, "t4_busy_active");
    expect_at(b+10, S_CSN, 32'hF, "t4_csn_rst");
    expect_at(b+10, S_BUSY, 32'h0, "t4_busy_rst");
    expect_at(b+10, S_STALL, 32'h0, "t4_stall_rst");
    expect_rng(b+10, b+13, S_EOT, 32'h0, "t4_no_eot");
    expect_at(b+13, S_CSN, 32'hF, "t4_csn_after");
    expect_at(b+13, S_BUSY, 32'h0, "t4_busy_after");
    expect_at(b+13, S_STALL, 32'h0, "t4_stall_after");
    go(b+5);  core_csn = 4'hD;
    go(b+9);  core_csn = 4'hF;
    go(b+10); rstn = 1'b0;
    go(b+12); rstn = 1'b1;
    go(b+15);

    // T5: release with simultaneous new request, served only after GAP; cpol latched
    b = cyc + 2;
    cfg_setup = 8'd2; cfg_hold = 8'd1; cfg_idle = 8'd4; cfg_cpol = 1'b1;
    expect_at(b+2, S_SCK, 32'h1, "t5_sck_cpol");
    expect_rng(b+6, b+11, S_CSN, 32'hE, "t5_csn_first");
    expect_rng(b+12, b+16, S_CSN, 32'hF, "t5_csn_gap");
    expect_rng(b+17, b+23, S_CSN, 32'h7, "t5_csn_second");
    expect_at(b+24, S_CSN, 32'hF, "t5_csn_rel");
    expect_at(b+12, S_STALL, 32'h1, "t5_stall_gap");
    expect_rng(b+16, b+18, S_STALL, 32'h1, "t5_stall_setup");
    expect_at(b+19, S_STALL, 32'h0, "t5_stall_active");
    expect_at(b+10, S_EOT, 32'h0, "t5_eot_pre");
    expect_at(b+11, S_EOT, 32'h1, "t5_eot1");
    expect_at(b+12, S_EOT, 32'h0, "t5_eot1_post");
    expect_at(b+23, S_EOT, 32'h1, "t5_eot2");
    expect_at(b+24, S_EOT, 32'h0, "t5_eot2_post");
    expect_at(b+16, S_BUSY, 32'h0, "t5_busy_idle");
    expect_at(b+17, S_BUSY, 32'h1, "t5_busy_second");
    expect_at(b+27, S_BUSY, 32'h1, "t5_busy_gap");
    expect_at(b+28, S_BUSY, 32'h0, "t5_busy_off");
    expect_at(b+17, S_ERR, 32'h0, "t5_err");
    expect_at(b+14, S_SCK, 32'h1, "t5_sck_cpol_held");
    expect_at(b+17, S_SCK, 32'h0, "t5_sck_cpol_new");
    go(b+5);  core_csn = 4'hE;
    go(b+10); core_csn = 4'h7;
    go(b+13); cfg_cpol = 1'b0;
    go(b+22); core_csn = 4'hF;
    go(b+30);

    if (sb.size() != 0) begin
      $display("FAIL scoreboard_drain: got=%0d pending expected=0", sb.size());
      n_bad += sb.size();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/udma_qspi_cs_sequencer.md
# udma_qspi_cs_sequencer

Parametrised pad-side chip-select and output-enable sequencer placed between the uDMA SPI master core and the QSPI pad structs. It generalises the fixed 4-CS, pure-wiring pad hookup to NUM_CS chip selects. It adds three programmable timing windows per transaction: CS-to-SCK setup, SCK-to-CS hold, and CS minimum idle gap. It also handles active-high pad output-enable generation and stalls the core while a window is running.

## Interface
- NUM_CS, 4, number of chip selects (1..8)
- NUM_SD, 4, number of data lines (1, 2 or 4)
- CNT_W, 8, width of delay counters and config fields
- periph_clk_i  in  1  peripheral clock
- rstn_i  in  1  asynchronous active-low reset
- cfg_setup_i  in  CNT_W  setup cycles, CS assert to first SCK
- cfg_hold_i  in  CNT_W  hold cycles, core CS release to pad CS release
- cfg_idle_i  in  CNT_W  minimum CS-high cycles between transactions
- cfg_cpol_i  in  1  SCK idle level
- core_csn_i  in  NUM_CS  active-low CS from core
- core_sck_i  in  1  SCK from core
- core_oen_i  in  NUM_SD  active-low output enables from core
- core_sdo_i  in  NUM_SD  serial data out from core
- core_stall_o  out  1  core must not advance SCK while high
- pad_csn_o  out  NUM_CS  active-low CS to pads
- pad_sck_o  out  1  SCK to pads
- pad_sd_oe_o  out  NUM_SD  active-high pad output enables
- pad_sdo_o  out  NUM_SD  data to pads
- busy_o  out  1  high in any state except IDLE
- eot_o  out  1  one-cycle pulse at end of HOLD
- err_o  out  1  one-cycle pulse on multi-CS request

## Operation
- FSM states: IDLE, SETUP, ACTIVE, HOLD, GAP.
- IDLE: a request is any bit of core_csn_i low. The lowest low index wins and is latched as cs_sel. If more than one bit is low, err_o pulses. cfg_* are latched. Next state is SETUP, or ACTIVE if the latched setup is 0. pad_csn_o[cs_sel] goes low in the next cycle.
- SETUP: counter loads latched setup value and decrements to 1, so the state lasts exactly that many cycles. Then ACTIVE.
- ACTIVE: SCK, SDO and OE pass through. When core_csn_i[cs_sel] goes high, or another bit goes low, next state is HOLD, or GAP directly if the latched hold is 0.
- HOLD: pad CS stays low for the latched hold value in cycles. eot_o pulses on the HOLD exit cycle, or on the ACTIVE exit cycle if hold is 0. Next state is GAP, or IDLE if the latched idle is 0.
- GAP: all pad CS are high for the latched idle value in cycles. New requests are ignored until IDLE.
- Outside ACTIVE: pad_sck_o = cfg_cpol_i latched value, pad_sd_oe_o = 0, pad_sdo_o = 0.
- core_stall_o = busy_o and state is not ACTIVE. It is also high in IDLE during the request-detect cycle.
- pad_sd_oe_o = ~core_oen_i, gated as above.
- Counters saturate at 0, never wrap. All cfg changes mid-transaction are ignored until the next IDLE.
- Reset mid-transaction: all outputs return immediately to reset values; no eot_o pulse.

## Timing
- All pad outputs and core_stall_o, busy_o, eot_o, err_o are registered. Core-to-pad latency is 1 cycle.
- Reset values: pad_csn_o all 1, pad_sck_o 0, pad_sd_oe_o 0, pad_sdo_o 0, core_stall_o 0, busy_o 0, eot_o 0, err_o 0.
- Request in cycle n with setup = S > 0: pad CS low from n+1. SCK passes from n+1+S.
- CS release in cycle m with hold = H, idle = I: pad CS high from m+1+H. IDLE is reached at m+1+H+I.
- Simultaneous release and new request: the release is processed first, and the new request is served after GAP.

## Configuration
- QSPI_OE_TURNAROUND_EN
  - Defined: when any core_oen_i bit goes from 1 to 0 during ACTIVE, the matching pad_sd_oe_o stays 0 for one extra cycle (bus turnaround). Disable (0 to 1) is never delayed.
  - Undefined: OE follows with plain 1-cycle latency.

## Structure
- udma_qspi_pkg holds the FSM state enum qspi_cs_state_e and the default CNT_W constant.
- One sub-module, udma_qspi_delay_cnt: a loadable down-counter with load, enable and done outputs. It is instantiated once and reused for the SETUP, HOLD and GAP windows.

## Test plan
- Setup/hold/idle window timing: S=3, H=2, I=4; core_csn_i=4'b1110 at cycle 10, released at 30. Expect pad_csn_o[0] low at cycles 11-32, eot_o at cycle 32, busy_o low from cycle 37, stall high at cycles 10-13.
- Zero windows: all cfg = 0. Expect pad CS to track core CS with 1-cycle latency, stall only in the request-detect cycle, and eot_o on the release+1 cycle.
- Multi-CS request: core_csn_i=4'b0101 in IDLE. Expect err_o single pulse, and only pad_csn_o[1] asserted.
- Reset in HOLD: rstn_i low at HOLD cycle 1. Expect pad_csn_o=4'hF immediately, no eot_o, and IDLE after release.
- OE turnaround (macro on): core_oen_i[1] 1→0 at ACTIVE cycle 5. Expect pad_sd_oe_o[1] high at cycle 7. With the macro off, expect cycle 6.
- Back-to-back: new request during GAP with I=4. Expect it ignored until IDLE, then served with full setup.
